// File: rtl/ddr_rd_block_sched_if.sv
// Signal bundle between the DDR read scheduler, the block writer and the read engine.
interface ddr_rd_block_sched_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              rd_en;
    logic              pl_ddr_wr_finish;
    logic              pl_ddr_rd_finish;
    logic              err_clr;
    logic              pl_ddr_rd_start;
    logic [ADDR_W-1:0] pl_ddr_rd_addr;
    logic [LEN_W-1:0]  pl_ddr_rd_length;
    logic              rd_busy;
    logic [CNT_W-1:0]  fill_level;
    logic              ovf_err;
    logic              tout_err;

    modport master (
        output rd_en, pl_ddr_wr_finish, pl_ddr_rd_finish, err_clr,
        input  pl_ddr_rd_start, pl_ddr_rd_addr, pl_ddr_rd_length, rd_busy,
               fill_level, ovf_err, tout_err
    );

    modport slave (
        input  rd_en, pl_ddr_wr_finish, pl_ddr_rd_finish, err_clr,
        output pl_ddr_rd_start, pl_ddr_rd_addr, pl_ddr_rd_length, rd_busy,
               fill_level, ovf_err, tout_err
    );
endinterface

// File: rtl/ddr_rd_block_sched.sv
// Ring-buffer DDR read scheduler: one read command per block finished by the writer,
// walking NUM_BLKS blocks circularly, with fill tracking and sticky overflow/timeout flags.
//
// state  | meaning
// IDLE   | no read outstanding; waits for rd_en and a pending block
// ISSUE  | launch read for current address, load timeout timer
// WAIT   | read outstanding; wait for rd_finish rise or timeout
// DONE   | read complete; advance address and consume block
module ddr_rd_block_sched #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LEN_W       = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned BLK_BYTES   = 32000,
    parameter int unsigned NUM_BLKS    = 6000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                 pl_clk,
    input  logic                 rst,
    ddr_rd_block_sched_if.slave  bus
);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(BASE_ADDR + (NUM_BLKS - 1) * BLK_BYTES);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(BLK_BYTES);
    localparam logic [LEN_W-1:0]  BLK_LEN = LEN_W'(BLK_BYTES);
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(NUM_BLKS);
    localparam int unsigned       TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]   TO_LOAD = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;
    localparam bit                TO_EN   = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic              wr_q, rd_q;
    logic              wr_rise, rd_rise;
    logic [TO_W-1:0]   to_cnt;
    logic              to_hit;
    logic              tout_set, ovf_set, blk_done;
    logic              rd_start_q, rd_busy_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [CNT_W-1:0]  fill_q;
    logic              ovf_q, tout_q;

    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            wr_q <= bus.pl_ddr_wr_finish;
            rd_q <= bus.pl_ddr_rd_finish;
        end
    end

    assign wr_rise = bus.pl_ddr_wr_finish & ~wr_q;
    assign rd_rise = bus.pl_ddr_rd_finish & ~rd_q;

    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tout_set  = 1'b0;
        blk_done  = 1'b0;
        case (state)
            S_IDLE:  if (bus.rd_en && (fill_q != '0)) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (rd_rise) begin
                    state_nxt = S_DONE;
                end else if (to_hit) begin
                    state_nxt = S_IDLE;
                    tout_set  = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                blk_done  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Down-counter: loaded while issuing, expires after TIMEOUT_CYC cycles in WAIT.
    assign to_hit = TO_EN && (to_cnt == '0);

    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == S_ISSUE) begin
            to_cnt <= TO_LOAD;
        end else if ((state == S_WAIT) && (to_cnt != '0)) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    // A write edge that lands on the same cycle as a consumed block cancels out.
    assign ovf_set = wr_rise && !blk_done && (fill_q == FULL);

    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            rd_start_q <= 1'b0;
            rd_busy_q  <= 1'b0;
            rd_addr_q  <= BASE_A;
            fill_q     <= '0;
            ovf_q      <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            rd_start_q <= (state == S_ISSUE);

            if (state == S_ISSUE)         rd_busy_q <= 1'b1;
            else if (blk_done || tout_set) rd_busy_q <= 1'b0;

            if (blk_done) rd_addr_q <= (rd_addr_q == LAST_A) ? BASE_A : rd_addr_q + STRIDE;

            if (wr_rise && !blk_done && !ovf_set) fill_q <= fill_q + 1'b1;
            else if (!wr_rise && blk_done)        fill_q <= fill_q - 1'b1;

            ovf_q  <= ovf_set  | (ovf_q  & ~bus.err_clr);
            tout_q <= tout_set | (tout_q & ~bus.err_clr);
        end
    end

    assign bus.pl_ddr_rd_start  = rd_start_q;
    assign bus.pl_ddr_rd_addr   = rd_addr_q;
    assign bus.pl_ddr_rd_length = BLK_LEN;
    assign bus.rd_busy          = rd_busy_q;
    assign bus.fill_level       = fill_q;
    assign bus.ovf_err          = ovf_q;
    assign bus.tout_err         = tout_q;
endmodule

// File: tb/tb_ddr_rd_block_sched.sv
// Bench for ddr_rd_block_sched: directed sequences, a table of fill/overflow steps,
// and a randomized write/read run checked against a block-index model of the ring.
`timescale 1ns/1ps
module tb_ddr_rd_block_sched;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 32;
    localparam int CNT_W  = 16;
    localparam int BASE   = 0;
    localparam int BLK    = 32000;
    localparam int NBLK   = 4;
    localparam int TOUT   = 16;
    localparam int NWR    = 30;

    logic pl_clk = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rd_idx   = 0;
    int   w_cnt    = 0;

    ddr_rd_block_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    ddr_rd_block_sched #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BASE_ADDR(BASE), .BLK_BYTES(BLK),
        .NUM_BLKS(NBLK), .CNT_W(CNT_W), .TIMEOUT_CYC(TOUT)
    ) dut (
        .pl_clk (pl_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 pl_clk = ~pl_clk;

    typedef struct {
        int n_wr;
        int clr;      // 0 none, 1 clear after writes, 2 clear coincident with the write edge
        int exp_fill;
        bit exp_ovf;
    } step_t;
    step_t steps[7];

    function automatic longint exp_addr(int k);
        return longint'(BASE) + longint'(k % NBLK) * longint'(BLK);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rd_en = 1'b0;
        bus.pl_ddr_wr_finish = 1'b0;
        bus.pl_ddr_rd_finish = 1'b0;
        bus.err_clr = 1'b0;
        repeat (2) @(posedge pl_clk);
        #1 rst = 1'b0;
        tick();
        rd_idx = 0;
        w_cnt  = 0;
    endtask

    task automatic pulse_wr();
        bus.pl_ddr_wr_finish = 1'b1;
        tick();
        bus.pl_ddr_wr_finish = 1'b0;
        tick();
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.pl_ddr_rd_start) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic serve_one(input int delay, output bit ok);
        bit seen;
        wait_start(seen);
        check("rd_start within budget", seen, 1);
        ok = seen;
        if (!seen) return;
        check("rd_addr", bus.pl_ddr_rd_addr, exp_addr(rd_idx));
        check("rd_length", bus.pl_ddr_rd_length, BLK);
        check("rd_busy during read", bus.rd_busy, 1);
        repeat (delay) tick();
        bus.pl_ddr_rd_finish = 1'b1;
        tick();
        bus.pl_ddr_rd_finish = 1'b0;
        tick();
        rd_idx++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen, ok;
        int cyc;

        steps[0] = '{n_wr: 1, clr: 0, exp_fill: 1, exp_ovf: 1'b0};
        steps[1] = '{n_wr: 2, clr: 0, exp_fill: 3, exp_ovf: 1'b0};
        steps[2] = '{n_wr: 1, clr: 0, exp_fill: 4, exp_ovf: 1'b0};
        steps[3] = '{n_wr: 1, clr: 0, exp_fill: 4, exp_ovf: 1'b1};
        steps[4] = '{n_wr: 0, clr: 1, exp_fill: 4, exp_ovf: 1'b0};
        steps[5] = '{n_wr: 1, clr: 2, exp_fill: 4, exp_ovf: 1'b1};
        steps[6] = '{n_wr: 0, clr: 1, exp_fill: 4, exp_ovf: 1'b0};

        do_reset();
        check("reset rd_start", bus.pl_ddr_rd_start, 0);
        check("reset rd_addr", bus.pl_ddr_rd_addr, BASE);
        check("reset rd_length", bus.pl_ddr_rd_length, BLK);
        check("reset rd_busy", bus.rd_busy, 0);
        check("reset fill", bus.fill_level, 0);
        check("reset ovf", bus.ovf_err, 0);
        check("reset tout", bus.tout_err, 0);

        // single block: issue latency and one-cycle strobe
        bus.rd_en = 1'b1;
        bus.pl_ddr_wr_finish = 1'b1;
        tick();
        bus.pl_ddr_wr_finish = 1'b0;
        check("single fill after write", bus.fill_level, 1);
        check("single start at N", bus.pl_ddr_rd_start, 0);
        tick();
        check("single start at N+1", bus.pl_ddr_rd_start, 0);
        tick();
        check("single start at N+2", bus.pl_ddr_rd_start, 1);
        check("single busy", bus.rd_busy, 1);
        check("single addr", bus.pl_ddr_rd_addr, exp_addr(0));
        tick();
        check("single strobe width", bus.pl_ddr_rd_start, 0);
        bus.pl_ddr_rd_finish = 1'b1;
        tick();
        bus.pl_ddr_rd_finish = 1'b0;
        tick();
        rd_idx = 1;
        check("single fill after read", bus.fill_level, 0);
        check("single addr advanced", bus.pl_ddr_rd_addr, exp_addr(1));
        check("single busy cleared", bus.rd_busy, 0);

        // three blocks queued, then drained; two more force the ring wrap
        do_reset();
        repeat (3) pulse_wr();
        check("three fill", bus.fill_level, 3);
        check("three no read while disabled", bus.rd_busy, 0);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) serve_one(2, ok);
        check("three drained", bus.fill_level, 0);
        repeat (2) pulse_wr();
        for (int i = 0; i < 2; i++) serve_one(1, ok);
        check("wrap read count", rd_idx, 5);
        check("addr after wrap read", bus.pl_ddr_rd_addr, exp_addr(5));

        // fill/overflow table with reads disabled
        bus.rd_en = 1'b0;
        foreach (steps[s]) begin
            for (int w = 0; w < steps[s].n_wr; w++) begin
                if (steps[s].clr == 2) bus.err_clr = 1'b1;
                bus.pl_ddr_wr_finish = 1'b1;
                tick();
                bus.pl_ddr_wr_finish = 1'b0;
                bus.err_clr = 1'b0;
                tick();
            end
            if (steps[s].clr == 1) begin
                bus.err_clr = 1'b1;
                tick();
                bus.err_clr = 1'b0;
            end
            tick();
            check($sformatf("table[%0d] fill", s), bus.fill_level, steps[s].exp_fill);
            check($sformatf("table[%0d] ovf", s), bus.ovf_err, steps[s].exp_ovf);
        end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) serve_one(1, ok);
        check("table drained fill", bus.fill_level, 0);

        // timeout: no rd_finish, the same block is retried
        pulse_wr();
        wait_start(seen);
        check("timeout first start", seen, 1);
        check("timeout first addr", bus.pl_ddr_rd_addr, exp_addr(rd_idx));
        cyc = 0;
        while (!bus.tout_err && cyc < 100) begin
            tick();
            cyc++;
        end
        check("timeout cycles", cyc, TOUT);
        check("timeout fill kept", bus.fill_level, 1);
        check("timeout busy cleared", bus.rd_busy, 0);
        serve_one(3, ok);
        check("timeout retry consumed", bus.fill_level, 0);
        check("timeout flag sticky", bus.tout_err, 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("timeout flag cleared", bus.tout_err, 0);

        // write edge on the DONE cycle leaves fill unchanged
        pulse_wr();
        wait_start(seen);
        check("coincident start", seen, 1);
        bus.pl_ddr_rd_finish = 1'b1;
        tick();
        bus.pl_ddr_rd_finish = 1'b0;
        bus.pl_ddr_wr_finish = 1'b1;
        tick();
        bus.pl_ddr_wr_finish = 1'b0;
        rd_idx++;
        check("coincident fill", bus.fill_level, 1);
        check("coincident ovf", bus.ovf_err, 0);
        check("coincident addr", bus.pl_ddr_rd_addr, exp_addr(rd_idx));
        serve_one(1, ok);
        check("coincident drained", bus.fill_level, 0);

        // asynchronous reset while a read is outstanding
        pulse_wr();
        wait_start(seen);
        check("rst-in-wait start", seen, 1);
        #2 rst = 1'b1;
        #1;
        check("rst-in-wait rd_start", bus.pl_ddr_rd_start, 0);
        check("rst-in-wait addr", bus.pl_ddr_rd_addr, BASE);
        check("rst-in-wait busy", bus.rd_busy, 0);
        check("rst-in-wait fill", bus.fill_level, 0);
        check("rst-in-wait length", bus.pl_ddr_rd_length, BLK);
        do_reset();
        check("after rst no start", bus.pl_ddr_rd_start, 0);

        // randomized writer against a responding read engine
        fork
            begin
                int i = 0;
                for (int it = 0; it < 3000 && i < NWR; it++) begin
                    bus.rd_en = ($urandom_range(0, 3) != 0);
                    repeat ($urandom_range(0, 4)) tick();
                    if (w_cnt - rd_idx < NBLK - 1) begin
                        pulse_wr();
                        w_cnt++;
                        i++;
                    end else begin
                        tick();
                    end
                end
                bus.rd_en = 1'b1;
            end
            begin
                for (int k = 0; k < NWR; k++) begin
                    bit rok;
                    serve_one($urandom_range(0, 8), rok);
                    if (!rok) break;
                    check("rand read had pending block", (w_cnt >= rd_idx), 1);
                end
            end
        join
        repeat (6) tick();
        check("rand read count", rd_idx, NWR);
        check("rand final fill", bus.fill_level, w_cnt - rd_idx);
        check("rand final addr", bus.pl_ddr_rd_addr, exp_addr(rd_idx));
        check("rand no ovf", bus.ovf_err, 0);
        check("rand no tout", bus.tout_err, 0);
        check("rand idle", bus.rd_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
